fifo_access_sched: RTL and testbench
====================================

// Module: fifo_access_sched
// PURPOSE
//  Sequences one shared FIFO (single wr/rd port, registered data_out, full/empty flags) between N_REQ writers and one reader.
//  Issues at most one FIFO command per cycle (wr XOR rd): the FIFO ignores simultaneous wr and rd.
//  Round-robins the writers, alternates read/write on conflict, and provides a flush sequence that drains the FIFO.
//  Sits between producer blocks and the FIFO instance; the reader sees a fixed-latency valid strobe.
// PARAMETERS
//  N_REQ  4  number of write requesters (>=2)
//  WIDTH  8  data width; must match the FIFO
//  DEPTH  8  FIFO depth; sizes the shadow occupancy counter (0..DEPTH)
// PORTS
//  clk            in   1            rising-edge clock
//  rst            in   1            synchronous, active-high reset
//  req            in   N_REQ        writer i has a word pending (level)
//  req_data       in   N_REQ*WIDTH  writer i data at [i*WIDTH +: WIDTH]
//  grant          out  N_REQ        one-hot pulse: writer i's word accepted this cycle
//  rd_req         in   1            reader wants one word (level)
//  rd_grant       out  1            pulse: read accepted this cycle
//  rd_valid       out  1            pulse: rd_data valid, exactly 2 cycles after rd_grant
//  rd_data        out  WIDTH        read word (driven from fifo_data_out)
//  flush          in   1            pulse/level: start drain when in RUN
//  flush_done     out  1            pulse: drain complete
//  fifo_wr        out  1            registered FIFO write strobe
//  fifo_rd        out  1            registered FIFO read strobe
//  fifo_data_in   out  WIDTH        registered FIFO write data
//  fifo_data_out  in   WIDTH        FIFO read data
//  fifo_full      in   1            FIFO full flag
//  fifo_empty     in   1            FIFO empty flag
//  err            out  1            sticky: FIFO flags disagree with shadow occupancy
// BEHAVIOUR
//  Reset: all outputs 0; state=RUN; occ=0; rr_ptr=0; pri=WRITE. The FIFO instance is reset from the same source (inverted for its active-low input).
//  Reset mid-operation discards all in-flight commands and pending rd_valid.
//  Decision cycle t (RUN): wr_ok = |req && occ<DEPTH; rd_ok = rd_req && occ>0.
//   only wr_ok -> write; only rd_ok -> read; both -> op = pri, then pri flips; neither -> idle.
//   pri changes only on conflict.
//  Write at t: grant[i]=1 in t (combinational, i = RR winner); fifo_wr=1 and fifo_data_in=req_data[i] in t+1; occ+1 at end of t.
//  Read at t: rd_grant=1 in t; fifo_rd=1 in t+1; rd_valid=1 in t+2 with rd_data=fifo_data_out; occ-1 at end of t.
//  RR: search starts at rr_ptr, wraps mod N_REQ; after granting i, rr_ptr=(i+1)%N_REQ; unchanged if no write grant.
//  Decisions use occ only (never the FIFO flags), so back-to-back writes to DEPTH and back-to-back reads to 0 run at full rate.
//  Flag check: fifo_full/fifo_empty in cycle c must equal (occ_d==DEPTH)/(occ_d==0), where occ_d = occ one cycle earlier.
//   Mismatch sets err, which clears only on rst.
//  FSM RUN->FLUSH when flush=1 (takes priority over the same-cycle rd/wr decision).
//   FLUSH: no grant or rd_grant; one read decision per cycle while occ>0; rd_valid suppressed for these reads.
//   FLUSH->DONE_WAIT when occ==0; DONE_WAIT holds 2 cycles for the last fifo_rd to retire; then flush_done=1 for 1 cycle -> RUN.
//   flush while not in RUN is ignored. A flush with occ==0 still completes via DONE_WAIT (flush_done 3 cycles after flush).
//  occ never exceeds DEPTH and never underflows; grants are never issued at the limits.
// STRUCTURE
//  Package fifo_sched_pkg: state encoding (RUN, FLUSH, DONE_WAIT), op encoding (OP_NONE, OP_WR, OP_RD), RD_LAT=2.
//  Sub-module rr_arbiter #(N): req, ptr -> one-hot gnt, any, idx.
//  Top level: occ counter, pri bit, command registers, 2-stage rd_valid/flush-suppress shift register, FSM, flag checker.
// TESTING (N_REQ=4, WIDTH=8, DEPTH=8, FIFO instance attached)
//  1 Reset, req=4'b1111 held with data 0x10..0x13 -> grants cycle 0,1,2,3,0,1,2,3; 8 writes total; grant stops at occ=8; err=0.
//  2 Fill with 8 words, then rd_req=1 -> 8 rd_valid pulses, data in write order; rd_grant stops at occ=0; each rd_valid exactly 2 cycles after its rd_grant.
//  3 occ=4, req[2]=1 and rd_req=1 held -> ops alternate W,R,W,R starting with W after reset; never fifo_wr&&fifo_rd.
//  4 occ=5, flush pulse -> 5 fifo_rd, no rd_valid, no grants; flush_done 2 cycles after occ hits 0; then writes accepted again.
//  5 rst asserted mid-burst (occ=3, read in flight) -> next cycle all outputs 0, occ=0, no stray rd_valid; normal resumption.
//  6 Force fifo_empty=0 while occ=0 -> err=1 next cycle and stays 1 until rst.

Source files
------------

// File: rtl/fifo_access_sched_pkg.sv
// fifo_sched_pkg: shared types and constants for the FIFO access scheduler.
//   state_e : scheduler FSM states
//   op_e    : FIFO command chosen in a decision cycle
//   RD_LAT  : cycles from rd_grant to rd_valid (one command register stage plus
//             the FIFO's registered data_out)
package fifo_sched_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      FLUSH     = 2'd1,
      DONE_WAIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_WR   = 2'd1,
      OP_RD   = 2'd2
   } op_e;

   localparam int RD_LAT = 2;

endpackage

// File: rtl/fifo_access_sched_if.sv
// fifo_access_sched_if: bundles the writer, reader, flush and FIFO-side signals
// of the scheduler.
//   master : the scheduler's view (drives grants, FIFO commands, status)
//   slave  : the environment's view (writers, reader, FIFO instance)
// Signals:
//   req/req_data/grant          writer requests, packed data, one-hot accept pulse
//   rd_req/rd_grant             reader request and accept pulse
//   rd_valid/rd_data            read return, RD_LAT cycles after rd_grant
//   flush/flush_done            drain request and completion pulse
//   fifo_wr/fifo_rd/fifo_data_in  registered FIFO command and write data
//   fifo_data_out/full/empty    FIFO read data and flags
//   err                         sticky flag/occupancy disagreement
interface fifo_access_sched_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ-1:0]       grant;
   logic                   rd_req;
   logic                   rd_grant;
   logic                   rd_valid;
   logic [WIDTH-1:0]       rd_data;
   logic                   flush;
   logic                   flush_done;
   logic                   fifo_wr;
   logic                   fifo_rd;
   logic [WIDTH-1:0]       fifo_data_in;
   logic [WIDTH-1:0]       fifo_data_out;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   err;

   modport master (
      input  req, req_data, rd_req, flush, fifo_data_out, fifo_full, fifo_empty,
      output grant, rd_grant, rd_valid, rd_data, flush_done,
             fifo_wr, fifo_rd, fifo_data_in, err
   );

   modport slave (
      output req, req_data, rd_req, flush, fifo_data_out, fifo_full, fifo_empty,
      input  grant, rd_grant, rd_valid, rd_data, flush_done,
             fifo_wr, fifo_rd, fifo_data_in, err
   );
endinterface

// File: rtl/fifo_access_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among N requesters.
//   req_i  : request vector
//   ptr_i  : index with highest priority this cycle; search wraps mod N
//   gnt_o  : one-hot winner (zero when no request)
//   any_o  : at least one request present
//   idx_o  : binary index of the winner
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          any_o,
   output logic [IW-1:0] idx_o
);

   function automatic logic [IW-1:0] pos(input int k);
      return IW'((int'(ptr_i) + k) % N);
   endfunction

   always_comb begin
      gnt_o = '0;
      any_o = 1'b0;
      idx_o = '0;
      for (int k = 0; k < N; k++) begin
         if (!any_o && req_i[pos(k)]) begin
            any_o         = 1'b1;
            gnt_o[pos(k)] = 1'b1;
            idx_o         = pos(k);
         end
      end
   end

endmodule

// File: rtl/fifo_access_sched.sv
// fifo_access_sched: shares one single-port FIFO between N_REQ writers and a
// reader, issuing at most one FIFO command per cycle, and drains it on flush.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fifo_access_sched_if.master (writers, reader, flush, FIFO side, err)
//
// state     | meaning
// RUN       | normal arbitration between writers and the reader
// FLUSH     | one internal read per cycle until shadow occupancy is zero
// DONE_WAIT | two cycles for the last fifo_rd to retire; flush_done in the 2nd
module fifo_access_sched
   import fifo_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   fifo_access_sched_if.master bus
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int OW = $clog2(DEPTH + 1);

   state_e            state_q;
   logic [OW-1:0]     occ_q, occ_d;
   logic [OW-1:0]     occ_dly_q;
   logic              pri_wr_q;
   logic              wait_q;
   logic [IW-1:0]     rr_ptr_q;
   logic              fifo_wr_q, fifo_rd_q;
   logic [WIDTH-1:0]  fifo_data_in_q;
   logic [RD_LAT-1:0] rd_sh_q;
   logic              flush_done_q;
   logic              err_q;

   logic [N_REQ-1:0]  arb_gnt;
   logic              arb_any;
   logic [IW-1:0]     arb_idx;
   logic              in_run, in_flush, wr_ok, rd_ok, rd_grant;
   op_e               op;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req_i (bus.req),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .any_o (arb_any),
      .idx_o (arb_idx)
   );

   // Decisions look only at the shadow occupancy; the FIFO flags lag by two
   // cycles and would throttle back-to-back traffic at the limits.
   always_comb begin
      in_run   = !rst && (state_q == RUN) && !bus.flush;
      in_flush = !rst && (state_q == FLUSH);
      wr_ok    = in_run && arb_any && (occ_q < OW'(DEPTH));
      rd_ok    = ((in_run && bus.rd_req) || in_flush) && (occ_q != '0);
      op       = OP_NONE;
      if (wr_ok && rd_ok)
         op = pri_wr_q ? OP_WR : OP_RD;
      else if (wr_ok)
         op = OP_WR;
      else if (rd_ok)
         op = OP_RD;
      occ_d = occ_q;
      if (op == OP_WR)
         occ_d = occ_q + 1'b1;
      else if (op == OP_RD)
         occ_d = occ_q - 1'b1;
      // Drain reads are internal: no rd_grant and no rd_valid for them.
      rd_grant = (op == OP_RD) && (state_q == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         occ_q          <= '0;
         occ_dly_q      <= '0;
         pri_wr_q       <= 1'b1;
         wait_q         <= 1'b0;
         rr_ptr_q       <= '0;
         fifo_wr_q      <= 1'b0;
         fifo_rd_q      <= 1'b0;
         fifo_data_in_q <= '0;
         rd_sh_q        <= '0;
         flush_done_q   <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         occ_q        <= occ_d;
         occ_dly_q    <= occ_q;
         fifo_wr_q    <= (op == OP_WR);
         fifo_rd_q    <= (op == OP_RD);
         rd_sh_q      <= {rd_sh_q[RD_LAT-2:0], rd_grant};
         flush_done_q <= 1'b0;

         if (op == OP_WR) begin
            fifo_data_in_q <= bus.req_data[int'(arb_idx)*WIDTH +: WIDTH];
            rr_ptr_q       <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
         end
         if (wr_ok && rd_ok)
            pri_wr_q <= !pri_wr_q;

         // FIFO flags reflect commands retired one cycle after the decision.
         if ((bus.fifo_full != (occ_dly_q == OW'(DEPTH))) ||
             (bus.fifo_empty != (occ_dly_q == '0)))
            err_q <= 1'b1;

         case (state_q)
            RUN: begin
               if (bus.flush)
                  state_q <= FLUSH;
            end
            FLUSH: begin
               if (occ_q == '0) begin
                  state_q <= DONE_WAIT;
                  wait_q  <= 1'b1;
               end
            end
            DONE_WAIT: begin
               if (wait_q) begin
                  wait_q       <= 1'b0;
                  flush_done_q <= 1'b1;
               end else begin
                  state_q <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign bus.grant        = (op == OP_WR) ? arb_gnt : '0;
   assign bus.rd_grant     = rd_grant;
   assign bus.rd_valid     = rd_sh_q[RD_LAT-1];
   assign bus.rd_data      = bus.fifo_data_out;
   assign bus.flush_done   = flush_done_q;
   assign bus.fifo_wr      = fifo_wr_q;
   assign bus.fifo_rd      = fifo_rd_q;
   assign bus.fifo_data_in = fifo_data_in_q;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_fifo_access_sched.sv
// Bench for fifo_access_sched with a behavioural FIFO attached. A queue-based
// reference model predicts grants per cycle and pushes expected FIFO commands
// and read returns into scoreboards; a monitor pops and compares them.
module tb_fifo_access_sched;

   localparam int N = 4;
   localparam int W = 8;
   localparam int D = 8;

   typedef struct {
      logic [W-1:0] d;
      int           c;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   fifo_access_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

   fifo_access_sched #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // behavioural FIFO: ignores simultaneous wr and rd, registered data_out
   logic [W-1:0] fm [D];
   int           f_wp, f_rp, f_cnt;
   logic [W-1:0] f_dout;
   logic         force_ne = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         f_wp <= 0; f_rp <= 0; f_cnt <= 0; f_dout <= '0;
      end else if (bus.fifo_wr && !bus.fifo_rd && f_cnt < D) begin
         fm[f_wp] <= bus.fifo_data_in;
         f_wp     <= (f_wp + 1) % D;
         f_cnt    <= f_cnt + 1;
      end else if (bus.fifo_rd && !bus.fifo_wr && f_cnt > 0) begin
         f_dout <= fm[f_rp];
         f_rp   <= (f_rp + 1) % D;
         f_cnt  <= f_cnt - 1;
      end
   end

   assign bus.fifo_data_out = f_dout;
   assign bus.fifo_full     = (f_cnt == D);
   assign bus.fifo_empty    = force_ne ? 1'b0 : (f_cnt == 0);

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // reference model state
   logic [W-1:0] mq [$];
   ev_t          exp_wr [$];
   ev_t          exp_rc [$];
   ev_t          exp_rv [$];
   int           rr, mode, fd_cyc, occ, wi;
   bit           pw, exp_err, wok, rok, dow, dor;
   logic [N-1:0] eg;
   bit           erg;
   logic [W-1:0] md;

   task automatic model_reset();
      mq.delete(); exp_wr.delete(); exp_rc.delete(); exp_rv.delete();
      rr = 0; pw = 1'b1; mode = 0; fd_cyc = -100; exp_err = 1'b0;
   endtask

   initial model_reset();

   // model: mode 0 = normal, 1 = draining, 2 = waiting for completion pulse
   always @(negedge clk) begin
      if (rst) begin
         model_reset();
      end else begin
         eg  = '0;
         erg = 1'b0;
         occ = mq.size();
         chk("err", bus.err, exp_err);
         if (force_ne) exp_err = 1'b1;
         chk("flush_done", bus.flush_done, cyc == fd_cyc);
         case (mode)
            0: begin
               if (bus.flush) begin
                  mode = 1;
               end else begin
                  wok = (|bus.req) && occ < D;
                  rok = bus.rd_req && occ > 0;
                  dow = wok && (!rok || pw);
                  dor = rok && (!wok || !pw);
                  if (wok && rok) pw = !pw;
                  if (dow) begin
                     wi = -1;
                     for (int k = 0; k < N; k++)
                        if (wi < 0 && bus.req[(rr + k) % N]) wi = (rr + k) % N;
                     eg[wi] = 1'b1;
                     md = bus.req_data[wi*W +: W];
                     mq.push_back(md);
                     exp_wr.push_back('{md, cyc + 1});
                     rr = (wi + 1) % N;
                  end
                  if (dor) begin
                     erg = 1'b1;
                     md  = mq.pop_front();
                     exp_rc.push_back('{md, cyc + 1});
                     exp_rv.push_back('{md, cyc + 2});
                  end
               end
            end
            1: begin
               if (occ > 0) begin
                  md = mq.pop_front();
                  exp_rc.push_back('{md, cyc + 1});
               end else begin
                  fd_cyc = cyc + 2;
                  mode   = 2;
               end
            end
            default: if (cyc == fd_cyc) mode = 0;
         endcase
         chk("grant", {28'd0, bus.grant}, {28'd0, eg});
         chk("rd_grant", bus.rd_grant, erg);
      end
   end

   // monitor: pops scoreboards when the DUT presents a command or return
   ev_t e;
   always @(negedge clk) begin
      if (!rst) begin
         chk("wr_and_rd", bus.fifo_wr && bus.fifo_rd, 1'b0);
         if (bus.fifo_wr) begin
            if (exp_wr.size() == 0) chk("fifo_wr_unexpected", 1, 0);
            else begin
               e = exp_wr.pop_front();
               chk("fifo_data_in", bus.fifo_data_in, e.d);
               chk("fifo_wr_cycle", cyc, e.c);
            end
         end else if (exp_wr.size() > 0 && exp_wr[0].c <= cyc) begin
            chk("fifo_wr_missing", 0, 1);
            void'(exp_wr.pop_front());
         end
         if (bus.fifo_rd) begin
            if (exp_rc.size() == 0) chk("fifo_rd_unexpected", 1, 0);
            else begin
               e = exp_rc.pop_front();
               chk("fifo_rd_cycle", cyc, e.c);
            end
         end else if (exp_rc.size() > 0 && exp_rc[0].c <= cyc) begin
            chk("fifo_rd_missing", 0, 1);
            void'(exp_rc.pop_front());
         end
         if (bus.rd_valid) begin
            if (exp_rv.size() == 0) chk("rd_valid_unexpected", 1, 0);
            else begin
               e = exp_rv.pop_front();
               chk("rd_data", bus.rd_data, e.d);
               chk("rd_valid_cycle", cyc, e.c);
            end
         end else if (exp_rv.size() > 0 && exp_rv[0].c <= cyc) begin
            chk("rd_valid_missing", 0, 1);
            void'(exp_rv.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int thr;

   initial begin
      bus.req      = '0;
      bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      bus.rd_req   = 1'b0;
      bus.flush    = 1'b0;
      rst          = 1'b1;
      tick(2);
      rst = 1'b0;

      // all writers pending: rotating grants until the FIFO is full
      bus.req = 4'hF;
      tick(12);
      bus.req = '0;

      // drain by reads in write order
      bus.rd_req = 1'b1;
      tick(12);
      bus.rd_req = 1'b0;
      tick(3);

      // occupancy 4, then writer 2 against the reader: alternating ops
      bus.req = 4'b0001;
      tick(4);
      bus.req    = 4'b0100;
      bus.rd_req = 1'b1;
      tick(10);
      bus.rd_req = 1'b0;
      bus.req    = 4'b0001;
      tick(1);
      bus.req = '0;

      // flush with data present, then writes again
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      tick(14);
      bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      bus.req      = 4'b1010;
      tick(4);
      bus.req = '0;

      // reset while a read is in flight
      bus.rd_req = 1'b1;
      tick(1);
      rst        = 1'b1;
      bus.rd_req = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(3);

      // flush with an empty FIFO
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      tick(6);

      // randomized traffic with varying read pressure and occasional flush
      for (int s = 0; s < 8; s++) begin
         thr = (s % 4) * 30 + 5;
         for (int i = 0; i < 50; i++) begin
            bus.req      = N'($urandom_range(0, 15));
            bus.req_data = $urandom();
            bus.rd_req   = ($urandom_range(0, 99) < thr);
            bus.flush    = ($urandom_range(0, 39) == 0);
            tick(1);
         end
      end
      bus.req    = '0;
      bus.rd_req = 1'b0;
      bus.flush  = 1'b0;
      tick(20);
      chk("scoreboard_drained", exp_wr.size() + exp_rc.size() + exp_rv.size(), 0);

      // flag disagreement makes err sticky until reset
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(2);
      force_ne = 1'b1;
      tick(1);
      force_ne = 1'b0;
      tick(5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
